// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - instruction prefetch stage: fetch FSM, request/grant memory port, instruction FIFO
module prefetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ce,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc
);
  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          r_state;
  logic            r_mem_req;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_discard;

  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [XLEN-1:0] r_fifo_instr [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_redirect;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_next;
  logic            w_credit_next;
  logic [XLEN-1:0] w_redirect_pc;

  // A redirect wins over both push and pop; the response returned in the
  // redirect cycle belongs to the old stream and is dropped.
  assign w_redirect    = i_ce & i_redirect_valid;
  assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);
  assign w_push        = i_ce & (r_state == S_WAIT) & i_mem_rvalid & ~r_discard & ~i_redirect_valid;
  assign w_pop         = i_ce & (r_count != '0) & i_instr_ready & ~i_redirect_valid;
  assign w_count_next  = w_redirect ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  // Occupancy after this edge decides whether the next request may be issued,
  // so the response it brings back always has a free slot.
  assign w_credit_next = (w_count_next < FULL);

  // Fetch FSM: one outstanding request at a time, address held until granted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_VECTOR;
      r_fetch_pc <= RESET_VECTOR;
      r_discard  <= 1'b0;
    end else if (i_ce) begin
      if (i_redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
      end
      case (r_state)
        S_IDLE: begin
          // A redirect here only reloads fetch_pc; the request starts next cycle.
          if (!i_redirect_valid && (r_count < FULL)) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_REQ: begin
          // The pending request cannot be withdrawn; mark its response stale.
          if (i_redirect_valid) begin
            r_discard <= 1'b1;
          end
          if (i_mem_gnt) begin
            r_state   <= S_WAIT;
            r_mem_req <= 1'b0;
            if (!i_redirect_valid && !r_discard) begin
              r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            r_discard <= 1'b0;
            if (w_credit_next) begin
              r_state    <= S_REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= i_redirect_valid ? w_redirect_pc : r_fetch_pc;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (i_redirect_valid) begin
            r_discard <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Instruction FIFO: {pc, instr} pairs, flushed by redirect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= RESET_VECTOR;
        r_fifo_instr[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_ce) begin
      if (i_redirect_valid) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]    <= r_mem_addr;
          r_fifo_instr[r_wr_ptr] <= i_mem_rdata;
          r_wr_ptr               <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
      r_count <= w_count_next;
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_instr_valid = (r_count != '0);
  assign o_instr       = r_fifo_instr[r_rd_ptr];
  assign o_instr_pc    = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - scoreboard bench for prefetch_unit with a randomized wait-state memory
module tb_prefetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int gnt_min  = 0;
  int gnt_max  = 0;
  int rv_min   = 1;
  int rv_max   = 1;

  logic [31:0] exp_q   [$];
  logic [31:0] gnt_log [$];

  always #5 clk = ~clk;

  prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ce            (ce),
    .o_mem_req       (mem_req),
    .o_mem_addr      (mem_addr),
    .i_mem_gnt       (mem_gnt),
    .i_mem_rvalid    (mem_rvalid),
    .i_mem_rdata     (mem_rdata),
    .o_instr_valid   (instr_valid),
    .o_instr         (instr),
    .o_instr_pc      (instr_pc),
    .i_instr_ready   (instr_ready),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected stream: sequential word addresses from pc, each returning pc^KEY
  task automatic expect_from(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 200; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  function automatic int count_range(input logic [31:0] lo, input logic [31:0] hi);
    int c = 0;
    foreach (gnt_log[i]) if (gnt_log[i] >= lo && gnt_log[i] < hi) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int target, input int limit, input string name);
    int n = 0;
    while (pops < target && n < limit) begin tick(); n++; end
    checks++;
    if (pops < target) begin
      failures++;
      $display("FAIL %s: got %0d pops expected %0d", name, pops, target);
    end
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    @(negedge clk);
    while (!mem_gnt && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (!mem_gnt) begin
      failures++;
      $display("FAIL %s: got mem_gnt=0 expected 1 within 60 cycles", name);
    end
  endtask

  task automatic wait_req_rise(input string name);
    int   n = 0;
    logic prev;
    @(negedge clk);
    prev = mem_req;
    @(negedge clk);
    while (!(mem_req && !prev) && n < 60) begin prev = mem_req; @(negedge clk); n++; end
    checks++;
    if (!mem_req) begin
      failures++;
      $display("FAIL %s: got mem_req=0 expected rising edge within 60 cycles", name);
    end
  endtask

  task automatic wait_req_and_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!(mem_req && instr_valid) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!(mem_req && instr_valid)) begin
      failures++;
      $display("FAIL %s: got req=%0b valid=%0b expected both 1", name, mem_req, instr_valid);
    end
  endtask

  // Memory: grant after gnt_min..gnt_max cycles, respond rv_min..rv_max cycles after grant
  initial begin : mem_model
    int          gcnt;
    int          rcnt;
    bit          busy;
    logic [31:0] raddr;
    gcnt = -1; rcnt = 0; busy = 1'b0; raddr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rst) begin
        busy = 1'b0;
        gcnt = -1;
      end else if (busy) begin
        if (rcnt <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = raddr ^ KEY;
          busy       = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (mem_req) begin
        if (gcnt < 0) gcnt = int'($urandom_range(gnt_max, gnt_min));
        if (gcnt == 0) begin
          mem_gnt = 1'b1;
          raddr   = mem_addr;
          gnt_log.push_back(mem_addr);
          busy    = 1'b1;
          rcnt    = int'($urandom_range(rv_max, rv_min));
          gcnt    = -1;
        end else begin
          gcnt--;
        end
      end
    end
  end

  // Monitor: every accepted instruction is compared against the scoreboard head
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && ce && instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got pc 0x%08h expected no instruction", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instr", instr, e ^ KEY);
        end
        pops++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [31:0] held_addr;
    logic [31:0] rpc;
    int          n0;
    int          target;
    int          n;
    rst = 1'b1; ce = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    expect_from(32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // ce low: nothing moves, redirect ignored
    rst = 1'b0; ce = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h800;
    repeat (3) begin
      tick();
      chk("ce0_mem_req", 32'(mem_req), 32'h0);
      chk("ce0_mem_addr", mem_addr, 32'h0);
    end
    redirect_valid = 1'b0; ce = 1'b1;
    tick();
    chk("first_req", 32'(mem_req), 32'h1);
    chk("first_addr", mem_addr, 32'h0);
    wait_pops(pops + 4, 100, "reset_stream");

    // Full FIFO: exactly DEPTH grants, then one pop buys one more
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; expect_from(32'h200);
    tick();
    redirect_valid = 1'b0;
    repeat (60) tick();
    chk("full_grants", 32'(count_range(32'h200, 32'h300)), 32'd4);
    chk("full_req", 32'(mem_req), 32'h0);
    chk("full_valid", 32'(instr_valid), 32'h1);
    chk("full_head_pc", instr_pc, 32'h200);
    ce = 1'b0; instr_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("ce0_hold_pc", instr_pc, 32'h200);
      chk("ce0_hold_req", 32'(mem_req), 32'h0);
    end
    ce = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("pop_head_pc", instr_pc, 32'h204);
    tick();
    chk("req_after_pop", 32'(mem_req), 32'h1);
    chk("addr_after_pop", mem_addr, 32'h210);
    repeat (30) tick();
    chk("grants_after_pop", 32'(count_range(32'h200, 32'h300)), 32'd5);
    chk("refull_req", 32'(mem_req), 32'h0);

    // Redirect while waiting, response arrives the next cycle and is dropped
    instr_ready = 1'b1; gnt_min = 0; gnt_max = 0; rv_min = 2; rv_max = 2;
    tick();
    wait_gnt("wait_gnt_wait_redirect");
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h102; instr_ready = 1'b0; expect_from(32'h100);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("drop_valid", 32'(instr_valid), 32'h0);
    chk("drop_next_req", 32'(mem_req), 32'h1);
    chk("drop_next_addr", mem_addr, 32'h100);
    instr_ready = 1'b1;
    wait_pops(pops + 3, 100, "after_wait_redirect");

    // Redirect while a request is pending a grant
    gnt_min = 3; gnt_max = 3; rv_min = 1; rv_max = 1;
    tick();
    wait_req_rise("wait_req_rise");
    tick();
    held_addr = mem_addr;
    n0 = gnt_log.size();
    redirect_valid = 1'b1; redirect_pc = 32'h400; expect_from(32'h400);
    tick();
    redirect_valid = 1'b0;
    chk("req_held", 32'(mem_req), 32'h1);
    chk("req_addr_held", mem_addr, held_addr);
    n = 0;
    while (gnt_log.size() < n0 + 2 && n < 60) begin tick(); n++; end
    chk("req_redirect_grants", 32'(gnt_log.size() - n0 >= 2), 32'h1);
    if (gnt_log.size() >= n0 + 2) begin
      chk("stale_grant_addr", gnt_log[n0], held_addr);
      chk("new_grant_addr", gnt_log[n0 + 1], 32'h400);
    end
    wait_pops(pops + 2, 100, "after_req_redirect");

    // Redirect and pop in the same cycle
    gnt_min = 0; gnt_max = 0;
    instr_ready = 1'b0;
    wait_req_and_valid("fill_for_pop_redirect");
    tick();
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h600; expect_from(32'h600);
    tick();
    redirect_valid = 1'b0;
    chk("pop_redirect_empty", 32'(instr_valid), 32'h0);
    wait_pops(pops + 2, 100, "after_pop_redirect");

    // Address wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9; expect_from(32'hFFFF_FFF8);
    tick();
    redirect_valid = 1'b0;
    wait_pops(pops + 4, 100, "wrap_stream");

    // Random wait states, random back-pressure, occasional redirects
    gnt_min = 0; gnt_max = 3; rv_min = 1; rv_max = 4;
    redirect_valid = 1'b1; redirect_pc = 32'h1000; expect_from(32'h1000);
    tick();
    redirect_valid = 1'b0;
    target = pops + 80;
    n = 0;
    while (pops < target && n < 4000) begin
      instr_ready = ($urandom_range(3, 0) != 0);
      if (redirect_valid) begin
        redirect_valid = 1'b0;
      end else if ($urandom_range(59, 0) == 0) begin
        rpc = $urandom;
        rpc[31:16] = 16'h0;
        redirect_valid = 1'b1;
        redirect_pc = rpc;
        expect_from(rpc & ~32'h3);
      end
      tick();
      n++;
    end
    redirect_valid = 1'b0;
    checks++;
    if (pops < target) begin
      failures++;
      $display("FAIL random_stream: got %0d pops expected %0d", pops, target);
    end

    // Asynchronous reset while a request is pending and the FIFO holds data
    instr_ready = 1'b0; gnt_min = 3; gnt_max = 3; rv_min = 1; rv_max = 1;
    tick();
    wait_req_and_valid("fill_for_reset");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'h0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk("async_rst_valid", 32'(instr_valid), 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_pc", instr_pc, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    gnt_min = 0; gnt_max = 0;
    expect_from(32'h0);
    rst = 1'b0; instr_ready = 1'b1;
    wait_pops(pops + 4, 100, "after_async_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
